// File: rtl/wshb_pkg.sv
// Shared Wishbone definitions: cycle-type / burst-type codes, responder FSM states,
// and the burst address increment used by both responders and masters.
// No logic of its own; pure constants, typedefs and one combinational helper.
package wshb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SINGLE,
    ST_BURST,
    ST_ERR
  } wshb_state_t;

  // Address of the beat following adr. Wrapping bursts keep the bits above the
  // wrap window and roll the low bits modulo N beats. data_bytes is a power of 2.
  function automatic logic [31:0] wshb_next_adr(input logic [31:0] adr,
                                                input logic [1:0]  bte,
                                                input int          data_bytes);
    logic [31:0] step;
    logic [31:0] span;
    logic [31:0] mask;
    logic [31:0] inc;
    step = 32'(data_bytes);
    case (bte)
      BTE_WRAP4:  span = step << 2;
      BTE_WRAP8:  span = step << 3;
      BTE_WRAP16: span = step << 4;
      default:    span = 32'd0;
    endcase
    inc  = adr + step;
    mask = span - 32'd1;
    if (bte == BTE_LINEAR) begin
      return inc;
    end
    return (adr & ~mask) | (inc & mask);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle with master and slave views.
// Ports: clk, rst (sync active-low); cyc/stb/adr/we/dat_ms/sel/cti/bte from master,
// ack/dat_sm/err/rty from slave.
interface wshb_if #(
  parameter int DATA_BYTES = 4
) (
  input logic clk,
  input logic rst
);
  logic                    cyc;
  logic                    stb;
  logic [31:0]             adr;
  logic                    we;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic                    err;
  logic                    rty;

  modport slave (
    input  clk, rst, cyc, stb, adr, we, dat_ms, sel, cti, bte,
    output ack, dat_sm, err, rty
  );

  modport master (
    input  clk, rst, ack, dat_sm, err, rty,
    output cyc, stb, adr, we, dat_ms, sel, cti, bte
  );
endinterface

// File: rtl/wshb_sp_ram.sv
// Single-port synchronous RAM, per-byte write enables, registered read (1 cycle).
// Ports: clk; addr (word index); we (one bit per byte lane); wdat; rdat (registered).
// No reset: contents and output register are left alone so block RAM can be inferred.
module wshb_sp_ram #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_BYTES-1:0]   we,
  input  logic [8*DATA_BYTES-1:0] wdat,
  output logic [8*DATA_BYTES-1:0] rdat
);

  logic [8*DATA_BYTES-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
    rdat <= mem[addr];
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone RAM responder: classic cycles and incrementing linear/wrap bursts with byte lanes.
// Latency: 1 wait cycle on the first beat, then one beat per cycle within a burst.
// Backpressure: a dropped stb/cyc aborts the burst; re-request restarts with a wait cycle.
// Ports: wshb_ifs (slave view of wshb_if: clk, rst, cyc, stb, adr, we, dat_ms, sel, cti,
// bte in; ack, dat_sm, err, rty out). Out-of-range addresses terminate with err.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  wshb_if.slave wshb_ifs
);

  localparam int LSB = $clog2(DATA_BYTES);

  wshb_state_t             state;
  wshb_state_t             state_nxt;
  logic                    req;
  logic                    hit;
  logic                    ack;
  logic                    err;
  logic                    wr;
  logic [31:0]             rd_adr;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_BYTES-1:0]   ram_we;
  logic [8*DATA_BYTES-1:0] ram_rdat;

  assign req = wshb_ifs.cyc & wshb_ifs.stb;
  assign hit = (wshb_ifs.adr[31:ADDR_WIDTH+LSB] == BASE_ADDR[31:ADDR_WIDTH+LSB]);

  always_ff @(posedge wshb_ifs.clk) begin
    if (!wshb_ifs.rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ack/err are combinational on req so a dropped cyc/stb terminates nothing.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    err       = 1'b0;
    rd_adr    = wshb_ifs.adr;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (!hit) begin
            state_nxt = ST_ERR;
          end else if (wshb_ifs.cti == CTI_INCR) begin
            state_nxt = ST_BURST;
          end else begin
            state_nxt = ST_SINGLE;
          end
        end
      end
      ST_SINGLE: begin
        ack       = req;
        state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        state_nxt = ST_IDLE;
        if (req && hit) begin
          ack = 1'b1;
          // Prefetch the next beat so the following cycle can ack without a wait.
          rd_adr = wshb_next_adr(wshb_ifs.adr, wshb_ifs.bte, DATA_BYTES);
          if (wshb_ifs.cti == CTI_INCR) begin
            state_nxt = ST_BURST;
          end
        end else if (req) begin
          err = 1'b1;
        end
      end
      ST_ERR: begin
        err       = req;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // One port serves both directions: a write cycle addresses the current beat,
  // otherwise the port reads ahead. Read data after a write is never consumed.
  assign wr       = ack & wshb_ifs.we;
  assign ram_we   = wr ? wshb_ifs.sel : '0;
  assign ram_addr = wr ? wshb_ifs.adr[ADDR_WIDTH+LSB-1:LSB] : rd_adr[ADDR_WIDTH+LSB-1:LSB];

  wshb_sp_ram #(
    .DATA_BYTES(DATA_BYTES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (wshb_ifs.clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdat (wshb_ifs.dat_ms),
    .rdat (ram_rdat)
  );

  assign wshb_ifs.ack    = ack;
  assign wshb_ifs.err    = err;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = ram_rdat;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Directed vector bench for wshb_ram_slave: each vector is one clock cycle of bus
// inputs plus the ack/err/data expected during that cycle.
module tb_wshb_ram_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  wshb_if #(.DATA_BYTES(4)) bus (.clk(clk), .rst(rst));

  wshb_ram_slave #(
    .DATA_BYTES(4),
    .ADDR_WIDTH(10),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .wshb_ifs(bus)
  );

  typedef struct {
    logic [63:0] nm;
    logic        r;
    logic        c;
    logic        s;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  sl;
    logic [2:0]  ct;
    logic [1:0]  bt;
    logic        e_ack;
    logic        e_err;
    logic        chk;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [63:0] nm, input logic r, input logic c,
                              input logic s, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] sl,
                              input logic [2:0] ct, input logic [1:0] bt,
                              input logic e_ack, input logic e_err,
                              input logic chk, input logic [31:0] e_dat);
    vec_t v;
    v.nm = nm; v.r = r; v.c = c; v.s = s; v.w = w; v.a = a; v.d = d; v.sl = sl;
    v.ct = ct; v.bt = bt; v.e_ack = e_ack; v.e_err = e_err; v.chk = chk; v.e_dat = e_dat;
    return v;
  endfunction

  // Classic write: one wait cycle, then ack.
  task automatic wr(input logic [63:0] nm, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] sl);
    vecs.push_back(mk(nm, 1, 1, 1, 1, a, d, sl, 3'b000, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk(nm, 1, 1, 1, 1, a, d, sl, 3'b000, 2'b00, 1, 0, 0, 0));
  endtask

  // Classic read: one wait cycle, then ack with data.
  task automatic rd(input logic [63:0] nm, input logic [31:0] a, input logic [31:0] e);
    vecs.push_back(mk(nm, 1, 1, 1, 0, a, 0, 4'hF, 3'b000, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk(nm, 1, 1, 1, 0, a, 0, 4'hF, 3'b000, 2'b00, 1, 0, 1, e));
  endtask

  // Burst read beat in the acked phase.
  task automatic bb(input logic [63:0] nm, input logic [31:0] a, input logic [2:0] ct,
                    input logic [1:0] bt, input logic [31:0] e);
    vecs.push_back(mk(nm, 1, 1, 1, 0, a, 0, 4'hF, ct, bt, 1, 0, 1, e));
  endtask

  task automatic idle(input logic [63:0] nm);
    vecs.push_back(mk(nm, 1, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 0, 0, 0, 0));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst        = v.r;
    bus.cyc    = v.c;
    bus.stb    = v.s;
    bus.we     = v.w;
    bus.adr    = v.a;
    bus.dat_ms = v.d;
    bus.sel    = v.sl;
    bus.cti    = v.ct;
    bus.bte    = v.bt;
    #4;
    n_vec++;
    if (bus.ack !== v.e_ack || bus.err !== v.e_err || bus.rty !== 1'b0 ||
        (v.chk && bus.dat_sm !== v.e_dat)) begin
      n_bad++;
      $display("FAIL %0s (vec %0d): got ack=%b err=%b rty=%b dat=%h, want ack=%b err=%b rty=0 dat=%h%0s",
               v.nm, n_vec, bus.ack, bus.err, bus.rty, bus.dat_sm, v.e_ack, v.e_err,
               v.e_dat, v.chk ? "" : "(unchecked)");
    end
  endtask

  initial begin
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = 0; bus.dat_ms = 0;
    bus.sel = 0; bus.cti = 0; bus.bte = 0;
    repeat (3) @(posedge clk);

    // Reset holds IDLE even with a request present.
    vecs.push_back(mk("rst_req", 0, 1, 1, 0, 32'h4, 0, 4'hF, 3'b000, 2'b00, 0, 0, 0, 0));
    idle("rst_idle");

    // Classic write/read and byte-lane merge.
    wr("wr_dead", 32'h4, 32'hDEADBEEF, 4'b1111);
    rd("rd_dead", 32'h4, 32'hDEADBEEF);
    wr("wr_lane1", 32'h4, 32'h0000AB00, 4'b0010);
    rd("rd_merge", 32'h4, 32'hDEADABEF);

    // Preload for bursts, error alias check and top-of-memory crossing.
    wr("pre_00", 32'h00, 32'h11111111, 4'hF);
    wr("pre_10", 32'h10, 32'd1, 4'hF);
    wr("pre_14", 32'h14, 32'd2, 4'hF);
    wr("pre_18", 32'h18, 32'd3, 4'hF);
    wr("pre_1c", 32'h1C, 32'd4, 4'hF);
    wr("pre_ff8", 32'hFF8, 32'h0000000A, 4'hF);
    wr("pre_ffc", 32'hFFC, 32'h0000000B, 4'hF);
    wr("pre_20", 32'h20, 32'h0, 4'hF);
    wr("pre_28", 32'h28, 32'h0, 4'hF);
    wr("pre_2c", 32'h2C, 32'h0, 4'hF);

    // Linear incrementing burst, then IDLE proven by a fresh 1-wait access.
    vecs.push_back(mk("lin_w", 1, 1, 1, 0, 32'h10, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    bb("lin_b1", 32'h10, 3'b010, 2'b00, 32'd1);
    bb("lin_b2", 32'h14, 3'b010, 2'b00, 32'd2);
    bb("lin_b3", 32'h18, 3'b010, 2'b00, 32'd3);
    bb("lin_b4", 32'h1C, 3'b111, 2'b00, 32'd4);
    idle("lin_end");
    rd("lin_post", 32'h10, 32'd1);

    // Wrap4 burst from 0x18: 0x18,0x1C,0x10,0x14.
    vecs.push_back(mk("wr4_w", 1, 1, 1, 0, 32'h18, 0, 4'hF, 3'b010, 2'b01, 0, 0, 0, 0));
    bb("wr4_b1", 32'h18, 3'b010, 2'b01, 32'd3);
    bb("wr4_b2", 32'h1C, 3'b010, 2'b01, 32'd4);
    bb("wr4_b3", 32'h10, 3'b010, 2'b01, 32'd1);
    bb("wr4_b4", 32'h14, 3'b111, 2'b01, 32'd2);
    idle("wr4_end");

    // Out-of-range classic read and write: err for one cycle, RAM (aliased word 0) untouched.
    vecs.push_back(mk("oor_rw", 1, 1, 1, 0, 32'h1000, 0, 4'hF, 3'b000, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("oor_rd", 1, 1, 1, 0, 32'h1000, 0, 4'hF, 3'b000, 2'b00, 0, 1, 0, 0));
    vecs.push_back(mk("oor_ww", 1, 1, 1, 1, 32'h1000, 32'h55555555, 4'hF, 3'b000, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("oor_wr", 1, 1, 1, 1, 32'h1000, 32'h55555555, 4'hF, 3'b000, 2'b00, 0, 1, 0, 0));
    rd("oor_keep", 32'h0, 32'h11111111);

    // Linear burst running off the top of memory.
    vecs.push_back(mk("top_w", 1, 1, 1, 0, 32'hFF8, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    bb("top_b1", 32'hFF8, 3'b010, 2'b00, 32'h0000000A);
    bb("top_b2", 32'hFFC, 3'b010, 2'b00, 32'h0000000B);
    vecs.push_back(mk("top_err", 1, 1, 1, 0, 32'h1000, 0, 4'hF, 3'b010, 2'b00, 0, 1, 0, 0));
    vecs.push_back(mk("top_idle", 1, 1, 1, 0, 32'h1004, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("err_gate", 1, 0, 0, 0, 32'h1004, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    idle("top_end");

    // Stall aborts a burst; the re-request pays the wait cycle again.
    vecs.push_back(mk("stl_w", 1, 1, 1, 0, 32'h10, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    bb("stl_b1", 32'h10, 3'b010, 2'b00, 32'd1);
    vecs.push_back(mk("stl_gap", 1, 1, 0, 0, 32'h14, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("stl_w2", 1, 1, 1, 0, 32'h14, 0, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    bb("stl_b2", 32'h14, 3'b010, 2'b00, 32'd2);
    bb("stl_b3", 32'h18, 3'b111, 2'b00, 32'd3);
    idle("stl_end");

    foreach (vecs[i]) apply(vecs[i]);

    // Reset during beat 2 of a write burst: beat 1 persists, beats 3-4 never land.
    apply(mk("rb_wait", 1, 1, 1, 1, 32'h20, 32'hC1, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    apply(mk("rb_b1", 1, 1, 1, 1, 32'h20, 32'hC1, 4'hF, 3'b010, 2'b00, 1, 0, 0, 0));
    apply(mk("rb_b2", 0, 1, 1, 1, 32'h24, 32'hC2, 4'hF, 3'b010, 2'b00, 1, 0, 0, 0));
    apply(mk("rb_b3", 0, 1, 1, 1, 32'h28, 32'hC3, 4'hF, 3'b010, 2'b00, 0, 0, 0, 0));
    apply(mk("rb_b4", 1, 1, 1, 1, 32'h2C, 32'hC4, 4'hF, 3'b111, 2'b00, 0, 0, 0, 0));
    apply(mk("rb_idle", 1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00, 0, 0, 0, 0));
    vecs.delete();
    rd("rb_rd20", 32'h20, 32'h000000C1);
    rd("rb_rd28", 32'h28, 32'h00000000);
    rd("rb_rd2c", 32'h2C, 32'h00000000);
    foreach (vecs[i]) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
